// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew data-hazard detection plus
// mult/div unit busy tracking, with a free-running stall performance counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [1:0]       id_tuse_rs,
  input  logic [1:0]       id_tuse_rt,
  input  logic             id_is_md,
  input  logic [4:0]       ex_wa,
  input  logic [1:0]       ex_tnew,
  input  logic [4:0]       mem_wa,
  input  logic [1:0]       mem_tnew,
  input  logic             ex_md_start,
  input  logic             ex_md_div,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  md_state_t  md_state, md_state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       stall_rs, stall_rt, stall_md, stall;

  // A source stalls when it is read before the in-flight producer can forward it
  always_comb begin
    stall_rs = (id_rs != 5'd0) && (id_tuse_rs != 2'd3) &&
               (((id_rs == ex_wa)  && (id_tuse_rs < ex_tnew)) ||
                ((id_rs == mem_wa) && (id_tuse_rs < mem_tnew)));
    stall_rt = (id_rt != 5'd0) && (id_tuse_rt != 2'd3) &&
               (((id_rt == ex_wa)  && (id_tuse_rt < ex_tnew)) ||
                ((id_rt == mem_wa) && (id_tuse_rt < mem_tnew)));
    stall_md = id_is_md && (md_busy || ex_md_start);
    stall    = !reset && (stall_rs || stall_rt || stall_md);
  end

  assign pc_en       = !stall;
  assign if_id_en    = !stall;
  assign id_ex_flush = stall;
  assign md_busy     = (md_state == MD_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= 4'd0;
    end else begin
      md_state <= md_state_nxt;
      md_cnt   <= md_cnt_nxt;
    end
  end

  // A start always (re)loads the count, even while already busy
  always_comb begin
    md_state_nxt = md_state;
    md_cnt_nxt   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (ex_md_start) begin
          md_cnt_nxt   = ex_md_div ? DIV_LD : MULT_LD;
          md_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (ex_md_start) begin
          md_cnt_nxt   = ex_md_div ? DIV_LD : MULT_LD;
        end else if (md_cnt == 4'd1) begin
          md_cnt_nxt   = 4'd0;
          md_state_nxt = MD_IDLE;
        end else begin
          md_cnt_nxt   = md_cnt - 4'd1;
        end
      end
      default: begin
        md_cnt_nxt   = 4'd0;
        md_state_nxt = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a timeline-based reference model checked
// every cycle, plus hand-computed expectations, on a 32-bit and a 4-bit counter build.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        id_is_md, ex_md_start, ex_md_div;
  logic        pc_en, if_id_en, id_ex_flush, md_busy;
  logic [31:0] stall_cnt;
  logic        pc_en4, if_id_en4, id_ex_flush4, md_busy4;
  logic [3:0]  stall_cnt4;

  int vectors = 0;
  int miscompares = 0;

  // model state: when the last md op was accepted and how long it lasts
  int          edge_n = 0;
  int          start_edge = 0;
  int          dur = 0;
  bit          started = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [3:0]  m_cnt4 = 4'd0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_flush(id_ex_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_flush(id_ex_flush4),
    .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  function automatic bit operandStalls(input logic [4:0] a, input logic [1:0] tuse);
    if (a == 5'd0 || tuse == 2'd3) return 1'b0;
    return ((a == ex_wa) && (tuse < ex_tnew)) || ((a == mem_wa) && (tuse < mem_tnew));
  endfunction

  // busy on the N edges-worth of cycles that follow the accepting edge
  function automatic bit modelBusy();
    return started && ((edge_n - start_edge) <= dur);
  endfunction

  function automatic bit modelStall();
    if (reset) return 1'b0;
    return operandStalls(id_rs, id_tuse_rs) || operandStalls(id_rt, id_tuse_rt) ||
           (id_is_md && (modelBusy() || ex_md_start));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b0;
      m_cnt   = 32'd0;
      m_cnt4  = 4'd0;
    end else begin
      if (modelStall()) begin
        m_cnt  = m_cnt + 32'd1;
        m_cnt4 = m_cnt4 + 4'd1;
      end
      if (ex_md_start) begin
        started    = 1'b1;
        start_edge = edge_n;
        dur        = ex_md_div ? 10 : 5;
      end
    end
    edge_n = edge_n + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model pc_en",       {31'd0, pc_en},       {31'd0, ~modelStall()});
    checkOutput("model if_id_en",    {31'd0, if_id_en},    {31'd0, ~modelStall()});
    checkOutput("model id_ex_flush", {31'd0, id_ex_flush}, {31'd0, modelStall()});
    checkOutput("model md_busy",     {31'd0, md_busy},     {31'd0, modelBusy()});
    checkOutput("model stall_cnt",   stall_cnt,            m_cnt);
    checkOutput("model flush4",      {31'd0, id_ex_flush4}, {31'd0, modelStall()});
    checkOutput("model md_busy4",    {31'd0, md_busy4},    {31'd0, modelBusy()});
    checkOutput("model stall_cnt4",  {28'd0, stall_cnt4},  {28'd0, m_cnt4});
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] turs, input logic [1:0] turt,
                               input logic is_md, input logic [4:0] ewa,
                               input logic [1:0] etn, input logic [4:0] mwa,
                               input logic [1:0] mtn, input logic start,
                               input logic div, input logic rst);
    id_rs = rs; id_rt = rt; id_tuse_rs = turs; id_tuse_rt = turt;
    id_is_md = is_md; ex_wa = ewa; ex_tnew = etn; mem_wa = mwa; mem_tnew = mtn;
    ex_md_start = start; ex_md_div = div; reset = rst;
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    idle();
    checkOutput("reset stall_cnt", stall_cnt, 32'd0);
    checkOutput("reset md_busy", {31'd0, md_busy}, 32'd0);
    checkOutput("reset pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("reset flush", {31'd0, id_ex_flush}, 32'd0);

    // load-use on rs through EX
    applyStimulus(5'd1, 5'd0, 2'd1, 2'd3, 1'b0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lw-use pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("lw-use if_id_en", {31'd0, if_id_en}, 32'd0);
    checkOutput("lw-use flush", {31'd0, id_ex_flush}, 32'd1);
    step();
    idle();
    checkOutput("lw-use stall_cnt", stall_cnt, 32'd1);

    applyStimulus(5'd0, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("r0 no stall", {31'd0, pc_en}, 32'd1);
    applyStimulus(5'd5, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mem tnew0 no stall", {31'd0, pc_en}, 32'd1);
    step();
    // rt hazard through MEM only
    applyStimulus(5'd0, 5'd7, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("rt mem stall", {31'd0, id_ex_flush}, 32'd1);
    step();
    idle();
    checkOutput("rt mem stall_cnt", stall_cnt, 32'd2);

    // mult start with md consumer waiting: start cycle + 5 busy cycles
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("mult start flush", {31'd0, id_ex_flush}, 32'd1);
    step();
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mult busy", {31'd0, md_busy}, 32'd1);
      step();
    end
    checkOutput("mult done busy", {31'd0, md_busy}, 32'd0);
    checkOutput("mult done flush", {31'd0, id_ex_flush}, 32'd0);
    checkOutput("mult stall_cnt", stall_cnt, 32'd8);

    // div runs 10 busy cycles
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    for (int i = 0; i < 10; i++) begin
      checkOutput("div busy", {31'd0, md_busy}, 32'd1);
      step();
    end
    checkOutput("div done busy", {31'd0, md_busy}, 32'd0);
    checkOutput("div stall_cnt", stall_cnt, 32'd8);

    // div aborted by reset at busy cycle 4, with hazards presented during reset
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    applyStimulus(5'd1, 5'd0, 2'd1, 2'd3, 1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("in-reset busy", {31'd0, md_busy}, 32'd1);
    checkOutput("in-reset pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("in-reset flush", {31'd0, id_ex_flush}, 32'd0);
    step();
    checkOutput("post-reset busy", {31'd0, md_busy}, 32'd0);
    checkOutput("post-reset stall_cnt", stall_cnt, 32'd0);
    idle();

    // 4-bit counter wraps after 16 stalls
    applyStimulus(5'd1, 5'd0, 2'd1, 2'd3, 1'b0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    checkOutput("cnt4 at max", {28'd0, stall_cnt4}, 32'd15);
    step();
    idle();
    checkOutput("cnt4 wrapped", {28'd0, stall_cnt4}, 32'd0);
    checkOutput("cnt32 no wrap", stall_cnt, 32'd16);

    // data and md hazard together count once
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(5'd1, 5'd0, 2'd1, 2'd3, 1'b1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("dual hazard flush", {31'd0, id_ex_flush}, 32'd1);
    step();
    idle();
    checkOutput("dual hazard stall_cnt", stall_cnt, 32'd17);
    for (int i = 0; i < 6; i++) step();
    checkOutput("final busy", {31'd0, md_busy}, 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
